// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ requesters, with
// repeated-START hold and start/busy watchdogs that abort hung transactions.
module i2c_txn_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TO_W     = 20,
  parameter int START_TO = 64,
  parameter int BUSY_TO  = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_hold,
  input  logic [8*N_REQ-1:0] req_addr_rw,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         m_address_rw,
  output logic               m_start,
  output logic               m_sr,
  output logic               m_abort,
  input  logic               m_busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1'b1);
  localparam logic [TO_W-1:0]  START_LAST = TO_W'(START_TO - 1);
  localparam logic [TO_W-1:0]  BUSY_LAST  = TO_W'(BUSY_TO - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    ACTIVE    = 3'd3,
    ABORT     = 3'd4,
    DONE      = 3'd5,
    HOLD      = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [IW-1:0]     ptr_r, ptr_s;
  logic [IW-1:0]     owner_r, owner_s;
  logic [N_REQ-1:0]  gnt_r, gnt_s;
  logic [N_REQ-1:0]  done_r, done_s;
  logic [N_REQ-1:0]  err_r, err_s;
  logic [7:0]        addr_r, addr_s;
  logic              start_r, start_s;
  logic              sr_r, sr_s;
  logic              abort_r, abort_s;
  logic [TO_W-1:0]   wd_r, wd_s;
  logic              sr_pend_r, sr_pend_s;
  logic              aborted_r, aborted_s;
  logic              found_s;
  logic [IW-1:0]     winner_s;
  logic [IW-1:0]     scan_s;

  // Round-robin search: first requester after ptr_r, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    scan_s   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_s = IW'((int'(ptr_r) + k) % N_REQ);
      if (!found_s && req[scan_s]) begin
        found_s  = 1'b1;
        winner_s = scan_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and next-output logic; pulse outputs are computed for the state being entered.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    owner_s   = owner_r;
    gnt_s     = gnt_r;
    addr_s    = addr_r;
    wd_s      = wd_r;
    sr_pend_s = sr_pend_r;
    aborted_s = aborted_r;
    done_s    = '0;
    err_s     = '0;
    start_s   = 1'b0;
    sr_s      = 1'b0;
    abort_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          ptr_s   = winner_s;
          owner_s = winner_s;
          gnt_s   = ONE_HOT0 << winner_s;
          addr_s  = req_addr_rw[int'(winner_s)*8 +: 8];
          start_s = 1'b1;
          sr_s    = sr_pend_r;
          state_s = LAUNCH;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        wd_s    = '0;
        state_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (m_busy) begin
          wd_s    = '0;
          state_s = ACTIVE;
        end else if (wd_r == START_LAST) begin
          abort_s = 1'b1;
          state_s = ABORT;
        end else begin
          wd_s    = wd_r + TO_W'(1);
        end
      end
      ACTIVE: begin
        // Completion takes priority over a coincident watchdog expiry.
        if (!m_busy) begin
          aborted_s = 1'b0;
          done_s    = gnt_r;
          state_s   = DONE;
        end else if (wd_r == BUSY_LAST) begin
          abort_s = 1'b1;
          state_s = ABORT;
        end else begin
          wd_s    = wd_r + TO_W'(1);
        end
      end
      ABORT: begin
        sr_pend_s = 1'b0;
        aborted_s = 1'b1;
        done_s    = gnt_r;
        err_s     = gnt_r;
        state_s   = DONE;
      end
      DONE: begin
        if (!aborted_r && req_hold[owner_r]) begin
          sr_pend_s = 1'b1;
          state_s   = HOLD;
        end else begin
          gnt_s     = '0;
          sr_pend_s = 1'b0;
          state_s   = IDLE;
        end
      end
      HOLD: begin
        if (req[owner_r]) begin
          addr_s  = req_addr_rw[int'(owner_r)*8 +: 8];
          start_s = 1'b1;
          sr_s    = sr_pend_r;
          state_s = LAUNCH;
        end else if (!req_hold[owner_r]) begin
          gnt_s     = '0;
          sr_pend_s = 1'b0;
          state_s   = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        gnt_s     = '0;
        sr_pend_s = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      ptr_r     <= IW'(N_REQ - 1);
      owner_r   <= '0;
      gnt_r     <= '0;
      done_r    <= '0;
      err_r     <= '0;
      addr_r    <= 8'h00;
      start_r   <= 1'b0;
      sr_r      <= 1'b0;
      abort_r   <= 1'b0;
      wd_r      <= '0;
      sr_pend_r <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      owner_r   <= owner_s;
      gnt_r     <= gnt_s;
      done_r    <= done_s;
      err_r     <= err_s;
      addr_r    <= addr_s;
      start_r   <= start_s;
      sr_r      <= sr_s;
      abort_r   <= abort_s;
      wd_r      <= wd_s;
      sr_pend_r <= sr_pend_s;
      aborted_r <= aborted_s;
    end
  end

  assign gnt          = gnt_r;
  assign done         = done_r;
  assign err          = err_r;
  assign m_address_rw = addr_r;
  assign m_start      = start_r;
  assign m_sr         = sr_r;
  assign m_abort      = abort_r;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter: arbitration, repeated START,
// watchdog aborts, completion/timeout race and mid-transaction reset.
module tb_i2c_txn_arbiter;

  localparam int START_TO = 8;
  localparam int BUSY_TO  = 150;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_hold;
  logic [31:0] req_addr_rw;
  logic [3:0]  gnt, done, err;
  logic [7:0]  m_address_rw;
  logic        m_start, m_sr, m_abort, m_busy;

  int checks = 0;
  int errors = 0;

  i2c_txn_arbiter #(.N_REQ(4), .TO_W(20), .START_TO(START_TO), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_hold(req_hold), .req_addr_rw(req_addr_rw),
    .gnt(gnt), .done(done), .err(err), .m_address_rw(m_address_rw), .m_start(m_start),
    .m_sr(m_sr), .m_abort(m_abort), .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for launch, plays master busy for busy_cyc cycles, waits for done.
  task automatic serve(input int busy_cyc, output logic [3:0] g, output logic sr,
                       output logic [7:0] a, output logic [3:0] d, output logic [3:0] e,
                       output bit to);
    int n;
    g = 4'h0; sr = 1'b0; a = 8'h00; d = 4'h0; e = 4'h0; to = 1'b0; n = 0;
    while (m_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (m_start !== 1'b1) begin
      to = 1'b1;
    end else begin
      g = gnt; sr = m_sr; a = m_address_rw;
      @(negedge clk);
      m_busy = 1'b1;
      repeat (busy_cyc) @(negedge clk);
      m_busy = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (done === 4'h0 && n < 300);
      d = done; e = err; to = (done === 4'h0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt, done, err, m_address_rw, m_start, m_sr, m_abort} !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b done=%b err=%b addr=%h st=%b sr=%b ab=%b",
               gnt, done, err, m_address_rw, m_start, m_sr, m_abort);
    end
  endtask

  task automatic test_single();
    int spurious;
    req_addr_rw[7:0] = 8'hA0;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if ({gnt, m_start, m_sr, m_address_rw} !== {4'b0001, 1'b1, 1'b0, 8'hA0}) begin
      errors++;
      $display("FAIL single_launch got gnt=%b st=%b sr=%b addr=%h exp 0001 1 0 a0",
               gnt, m_start, m_sr, m_address_rw);
    end
    req_addr_rw[7:0] = 8'h55;
    @(negedge clk);
    checks++;
    if (m_start !== 1'b0) begin errors++; $display("FAIL single_start_width got %b exp 0", m_start); end
    m_busy = 1'b1;
    spurious = 0;
    repeat (100) begin
      @(negedge clk);
      if (m_start || m_abort || (done != 4'h0)) spurious++;
    end
    checks++;
    if (spurious != 0 || m_address_rw !== 8'hA0) begin
      errors++;
      $display("FAIL single_busy got spurious=%0d addr=%h exp 0 a0", spurious, m_address_rw);
    end
    m_busy = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, err} !== {4'b0001, 4'b0000}) begin
      errors++; $display("FAIL single_done got done=%b err=%b exp 0001 0000", done, err);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({done, gnt} !== 8'h00) begin
      errors++; $display("FAIL single_release got done=%b gnt=%b exp 0000 0000", done, gnt);
    end
  endtask

  task automatic test_rr();
    logic [3:0] g, d, e, exp_g;
    logic [7:0] a, exp_a;
    logic sr;
    bit to;
    do_reset();
    req_addr_rw = {8'h00, 8'h20, 8'h00, 8'h10};
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      serve(3, g, sr, a, d, e, to);
      exp_g = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      exp_a = (i % 2 == 0) ? 8'h10 : 8'h20;
      checks++;
      if (to || g !== exp_g || d !== exp_g || e !== 4'h0 || a !== exp_a || sr !== 1'b0) begin
        errors++;
        $display("FAIL rr_%0d got to=%0d gnt=%b done=%b err=%b addr=%h sr=%b exp gnt=done=%b addr=%h",
                 i, to, g, d, e, a, sr, exp_g, exp_a);
      end
      req = req & ~g;
      @(negedge clk);
      if (i < 3) req = req | g;
    end
    req = 4'b0000;
  endtask

  task automatic test_hold();
    logic [3:0] g, d, e;
    logic [7:0] a;
    logic sr;
    bit to;
    int starts;
    req_addr_rw = {8'h00, 8'h30, 8'hA0, 8'h00};
    req_hold = 4'b0010;
    req = 4'b0010;
    serve(3, g, sr, a, d, e, to);
    checks++;
    if (to || g !== 4'b0010 || sr !== 1'b0 || a !== 8'hA0 || d !== 4'b0010 || e !== 4'h0) begin
      errors++;
      $display("FAIL hold_first got to=%0d gnt=%b sr=%b addr=%h done=%b err=%b", to, g, sr, a, d, e);
    end
    req = 4'b0100;
    starts = 0;
    repeat (5) begin @(negedge clk); if (m_start) starts++; end
    checks++;
    if (gnt !== 4'b0010 || starts != 0) begin
      errors++; $display("FAIL hold_keep got gnt=%b starts=%0d exp 0010 0", gnt, starts);
    end
    req_addr_rw[15:8] = 8'hA1;
    req = 4'b0110;
    serve(3, g, sr, a, d, e, to);
    checks++;
    if (to || g !== 4'b0010 || sr !== 1'b1 || a !== 8'hA1 || d !== 4'b0010 || e !== 4'h0) begin
      errors++;
      $display("FAIL hold_sr got to=%0d gnt=%b sr=%b addr=%h done=%b err=%b", to, g, sr, a, d, e);
    end
    req = 4'b0100;
    req_hold = 4'b0000;
    serve(3, g, sr, a, d, e, to);
    checks++;
    if (to || g !== 4'b0100 || sr !== 1'b0 || a !== 8'h30 || d !== 4'b0100) begin
      errors++;
      $display("FAIL hold_release got to=%0d gnt=%b sr=%b addr=%h done=%b exp 0100 0 30 0100",
               to, g, sr, a, d);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_start_timeout();
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    repeat (START_TO - 1) @(negedge clk);
    checks++;
    if (m_abort !== 1'b0) begin errors++; $display("FAIL start_to_early got m_abort=%b exp 0", m_abort); end
    @(negedge clk);
    checks++;
    if (m_abort !== 1'b1 || gnt !== 4'b0001) begin
      errors++; $display("FAIL start_to_abort got m_abort=%b gnt=%b exp 1 0001", m_abort, gnt);
    end
    @(negedge clk);
    checks++;
    if ({done, err, m_abort} !== {4'b0001, 4'b0001, 1'b0}) begin
      errors++; $display("FAIL start_to_err got done=%b err=%b ab=%b exp 0001 0001 0", done, err, m_abort);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({gnt, done, err} !== 12'h000) begin
      errors++; $display("FAIL start_to_idle got gnt=%b done=%b err=%b exp 0", gnt, done, err);
    end
  endtask

  task automatic test_busy_timeout();
    logic [3:0] g, d, e;
    logic [7:0] a;
    logic sr;
    bit to;
    req = 4'b1010;
    @(negedge clk);
    m_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    repeat (BUSY_TO - 1) @(negedge clk);
    checks++;
    if (m_abort !== 1'b0) begin errors++; $display("FAIL busy_to_early got m_abort=%b exp 0", m_abort); end
    @(negedge clk);
    checks++;
    if (m_abort !== 1'b1 || gnt !== 4'b0010) begin
      errors++; $display("FAIL busy_to_abort got m_abort=%b gnt=%b exp 1 0010", m_abort, gnt);
    end
    m_busy = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, err} !== {4'b0010, 4'b0010}) begin
      errors++; $display("FAIL busy_to_err got done=%b err=%b exp 0010 0010", done, err);
    end
    req = 4'b1000;
    serve(3, g, sr, a, d, e, to);
    checks++;
    if (to || g !== 4'b1000 || d !== 4'b1000 || e !== 4'h0) begin
      errors++; $display("FAIL busy_to_next got to=%0d gnt=%b done=%b err=%b exp 1000", to, g, d, e);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_race();
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    m_busy = 1'b1;
    repeat (BUSY_TO) @(negedge clk);
    m_busy = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, err, m_abort} !== {4'b0001, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL race_done got done=%b err=%b ab=%b exp 0001 0000 0", done, err, m_abort);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] g, d, e;
    logic [7:0] a;
    logic sr;
    bit to;
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    m_busy = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if ({gnt, done, err, m_address_rw, m_start, m_sr, m_abort} !== 23'h0) begin
      errors++;
      $display("FAIL reset_mid got gnt=%b done=%b err=%b addr=%h st=%b sr=%b ab=%b",
               gnt, done, err, m_address_rw, m_start, m_sr, m_abort);
    end
    m_busy = 1'b0;
    reset = 1'b0;
    serve(3, g, sr, a, d, e, to);
    checks++;
    if (to || g !== 4'b0001 || d !== 4'b0001) begin
      errors++; $display("FAIL reset_ptr got to=%0d gnt=%b done=%b exp 0001", to, g, d);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req = 4'h0;
    req_hold = 4'h0;
    req_addr_rw = 32'h0;
    m_busy = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_rr();
    test_hold();
    test_start_timeout();
    test_busy_timeout();
    test_race();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
